// File: rtl/clk_rst_pkg.sv
// Shared definitions for the pixel-domain reset sequencer: FSM state
// encodings and the lock-loss counter width/saturation helper.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABILIZE = 3'd1,
    ST_REL_MOUSE = 3'd2,
    ST_REL_VIDEO = 3'd3,
    ST_REL_CORE  = 3'd4,
    ST_RUN       = 3'd5
  } seq_state_e;

  localparam int unsigned LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'hFF;

  // Increment that sticks at LOSS_CNT_MAX instead of wrapping.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    if (v == LOSS_CNT_MAX) begin
      return v;
    end
    return v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for signals arriving asynchronously to
// clk_i. Both stages clear to 0 under the synchronous active-low reset.
// Ports:
//   clk_i   destination clock
//   rst_ni  synchronous active-low reset
//   d_i     asynchronous input
//   q_o     synchronized output (two clk_i edges of latency)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_reset_sequencer.sv
// Staged reset release for the pixel-clock domain. Qualifies PLL lock for
// LOCK_STABLE_CYCLES, then releases mouse, video and core resets STAGE_GAP
// cycles apart and finally raises ready. Lock loss or a software request
// re-runs the sequence; lock losses after the first release are counted.
// Ports:
//   clk            pixel clock
//   rst            synchronous active-low reset
//   locked_in      PLL lock, asynchronous to clk
//   soft_rst_req   single-cycle re-sequence request
//   rst_mouse_out  active-high reset, mouse logic
//   rst_video_out  active-high reset, timing/draw pipeline
//   rst_core_out   active-high reset, game core
//   ready          all subsystems out of reset
//   lock_loss_cnt  saturating lock-loss count
//   state_dbg      current FSM state encoding
module clk_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP          = 16,
  parameter int unsigned CNT_W              = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked_in,
  input  logic                  soft_rst_req,
  output logic                  rst_mouse_out,
  output logic                  rst_video_out,
  output logic                  rst_core_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]            state_dbg
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic                  locked_s;
  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  rst_mouse_q, rst_mouse_d;
  logic                  rst_video_q, rst_video_d;
  logic                  rst_core_q, rst_core_d;
  logic                  ready_q, ready_d;

  sync_2ff u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (locked_in),
    .q_o    (locked_s)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      loss_q      <= '0;
      rst_mouse_q <= 1'b1;
      rst_video_q <= 1'b1;
      rst_core_q  <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      rst_mouse_q <= rst_mouse_d;
      rst_video_q <= rst_video_d;
      rst_core_q  <= rst_core_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic; priority is lock loss, then soft request, then counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end
      end

      ST_STABILIZE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_REL_MOUSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_REL_MOUSE, ST_REL_VIDEO, ST_REL_CORE, ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          loss_d  = sat_inc(loss_q);
        end else if (soft_rst_req) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (state_q != ST_RUN) begin
          if (cnt_q == GAP_LAST) begin
            case (state_q)
              ST_REL_MOUSE: state_d = ST_REL_VIDEO;
              ST_REL_VIDEO: state_d = ST_REL_CORE;
              default:      state_d = ST_RUN;
            endcase
            // Counter stays frozen once RUN is reached.
            cnt_d = (state_q == ST_REL_CORE) ? cnt_q : '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they only move on transitions.
    rst_mouse_d = !(state_d inside {ST_REL_MOUSE, ST_REL_VIDEO, ST_REL_CORE, ST_RUN});
    rst_video_d = !(state_d inside {ST_REL_VIDEO, ST_REL_CORE, ST_RUN});
    rst_core_d  = !(state_d inside {ST_REL_CORE, ST_RUN});
    ready_d     = (state_d == ST_RUN);
  end

  assign rst_mouse_out = rst_mouse_q;
  assign rst_video_out = rst_video_q;
  assign rst_core_out  = rst_core_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Bench for clk_reset_sequencer with L=8, G=4. The reference model tracks
// only "sequence active" and the age (edges since qualification began);
// every output is derived from the age against the release milestones.
module tb_clk_reset_sequencer;

  localparam int L = 8;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked_in;
  logic       soft_rst_req;
  logic       rst_mouse_out;
  logic       rst_video_out;
  logic       rst_core_out;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_dbg;
  logic [14:0] obs_vec;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic m_s1, m_s2;
  logic m_active;
  int   m_age;
  int   m_loss;

  clk_reset_sequencer #(
    .LOCK_STABLE_CYCLES (L),
    .STAGE_GAP          (G),
    .CNT_W              (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .locked_in     (locked_in),
    .soft_rst_req  (soft_rst_req),
    .rst_mouse_out (rst_mouse_out),
    .rst_video_out (rst_video_out),
    .rst_core_out  (rst_core_out),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  assign obs_vec = {rst_mouse_out, rst_video_out, rst_core_out, ready, state_dbg, lock_loss_cnt};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] model_out();
    logic rm, rv, rc, rd;
    int   st;
    rm = !(m_active && m_age >= L);
    rv = !(m_active && m_age >= L + G);
    rc = !(m_active && m_age >= L + 2 * G);
    rd =  (m_active && m_age >= L + 3 * G);
    if (!m_active)              st = 0;
    else if (m_age < L)         st = 1;
    else if (m_age < L + G)     st = 2;
    else if (m_age < L + 2 * G) st = 3;
    else if (m_age < L + 3 * G) st = 4;
    else                        st = 5;
    return {rm, rv, rc, rd, 3'(st), 8'(m_loss)};
  endfunction

  // One clock: drive at negedge, advance the model at posedge, check #1 later.
  task automatic step(input logic r, input logic lk, input logic sf, input string tag);
    logic ls;
    @(negedge clk);
    rst          = r;
    locked_in    = lk;
    soft_rst_req = sf;
    @(posedge clk);
    ls = m_s2;
    if (!r) begin
      m_active = 1'b0;
      m_age    = 0;
      m_loss   = 0;
      m_s1     = 1'b0;
      m_s2     = 1'b0;
    end else begin
      if (!m_active) begin
        if (ls) begin
          m_active = 1'b1;
          m_age    = 0;
        end
      end else if (!ls) begin
        if (m_age >= L && m_loss < 255) m_loss++;
        m_active = 1'b0;
        m_age    = 0;
      end else if (sf && m_age >= L) begin
        m_age = 0;
      end else if (m_age < L + 3 * G) begin
        m_age++;
      end
      m_s2 = m_s1;
      m_s1 = lk;
    end
    #1;
    chk(tag, 32'(obs_vec), 32'(model_out()));
  endtask

  initial begin
    logic lk;
    logic sf;
    logic r;
    int   n;

    rst = 1'b0; locked_in = 1'b0; soft_rst_req = 1'b0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_active = 1'b0; m_age = 0; m_loss = 0;

    // Reset and idle without lock.
    repeat (5) step(1'b0, 1'b0, 1'b0, "reset");
    chk("reset_vals", 32'(obs_vec), 32'(15'b111_0_000_00000000));
    repeat (20) step(1'b1, 1'b0, 1'b0, "idle");
    chk("idle_hold", 32'(obs_vec), 32'(15'b111_0_000_00000000));

    // Nominal release; loop index e is the edge number from the first lock sample.
    for (int e = 0; e <= 25; e++) begin
      step(1'b1, 1'b1, 1'b0, "nominal");
      if (e == 9)  chk("mouse_e9",  32'(rst_mouse_out), 32'd1);
      if (e == 10) chk("mouse_e10", 32'(rst_mouse_out), 32'd0);
      if (e == 13) chk("video_e13", 32'(rst_video_out), 32'd1);
      if (e == 14) chk("video_e14", 32'(rst_video_out), 32'd0);
      if (e == 17) chk("core_e17",  32'(rst_core_out),  32'd1);
      if (e == 18) chk("core_e18",  32'(rst_core_out),  32'd0);
      if (e == 21) chk("ready_e21", 32'(ready),         32'd0);
      if (e == 22) begin
        chk("ready_e22", 32'(ready),     32'd1);
        chk("state_e22", 32'(state_dbg), 32'd5);
      end
    end

    // Soft reset in RUN.
    step(1'b1, 1'b1, 1'b1, "soft_req");
    chk("soft_state",  32'(state_dbg), 32'd1);
    chk("soft_resets", 32'({rst_mouse_out, rst_video_out, rst_core_out, ready}), 32'(4'b1110));
    for (int k = 1; k <= L + 3 * G; k++) begin
      step(1'b1, 1'b1, 1'b0, "soft_reseq");
      if (k == L + 3 * G - 1) chk("soft_ready_pre", 32'(ready), 32'd0);
      if (k == L + 3 * G)     chk("soft_ready",     32'(ready), 32'd1);
    end

    // Soft request coinciding with synchronized lock loss counts as a loss.
    step(1'b1, 1'b0, 1'b0, "sl_drop");
    step(1'b1, 1'b0, 1'b0, "sl_drop");
    step(1'b1, 1'b0, 1'b1, "sl_both");
    chk("sl_state", 32'(state_dbg),     32'd0);
    chk("sl_loss",  32'(lock_loss_cnt), 32'd1);
    repeat (L + 3 * G + 4) step(1'b1, 1'b1, 1'b0, "sl_relock");

    // Repeated lock loss in RUN until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(1, 4);
      repeat (n) step(1'b1, 1'b0, 1'b0, "loss_drop");
      repeat (L + 3 * G + 4) step(1'b1, 1'b1, 1'b0, "loss_relock");
    end
    chk("loss_sat",   32'(lock_loss_cnt), 32'd255);
    chk("loss_ready", 32'(ready),         32'd1);

    // Synchronous reset taken in REL_VIDEO.
    step(1'b1, 1'b1, 1'b1, "mid_soft");
    repeat (L + G) step(1'b1, 1'b1, 1'b0, "mid_seq");
    chk("mid_video", 32'(state_dbg), 32'd3);
    step(1'b0, 1'b1, 1'b0, "mid_rst");
    chk("mid_rst_vals", 32'(obs_vec), 32'(15'b111_0_000_00000000));
    repeat (3) step(1'b1, 1'b0, 1'b0, "mid_idle");

    // Glitchy lock during qualification.
    repeat (5) step(1'b1, 1'b1, 1'b0, "glitch_hi");
    step(1'b1, 1'b0, 1'b0, "glitch_lo");
    for (int e = 0; e <= L + 3; e++) begin
      step(1'b1, 1'b1, 1'b0, "glitch");
      if (e == 1)     chk("glitch_wait", 32'(state_dbg),     32'd0);
      if (e == L + 1) chk("glitch_m_hi", 32'(rst_mouse_out), 32'd1);
      if (e == L + 2) chk("glitch_m_lo", 32'(rst_mouse_out), 32'd0);
    end
    chk("glitch_loss", 32'(lock_loss_cnt), 32'd0);

    // Random lock, soft-request and reset activity against the model.
    lk = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      sf = ($urandom_range(0, 29) == 0);
      r  = !($urandom_range(0, 299) == 0);
      step(r, lk, sf, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
